// File: rtl/hpvi_ctrl.sv
// Parametrised priority vectored interrupt controller: edge/level capture, maskable
// fixed-priority arbitration, nested in-service tracking and an ack/EOI handshake.
module hpvi_ctrl #(
  parameter int                 numInts  = 8,
  parameter int                 idWidth  = 3,
  parameter int                 pcWidth  = 16,
  parameter int                 addrLen  = 2,
  parameter logic [numInts-1:0] edgeTrig = {numInts{1'b1}}
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [numInts-1:0] ints,
  input  logic [numInts-1:0] maskIn,
  input  logic               ldMask,
  input  logic               clrMask,
  input  logic               intDisable,
  input  logic [pcWidth-1:0] vecBase,
  input  logic               intAck,
  input  logic               intEoi,
  output logic               intPending,
  output logic [idWidth-1:0] intId,
  output logic [pcWidth-1:0] intAddr,
  output logic [numInts-1:0] inService
);

  logic [numInts-1:0] ints_q, ints_d;
  logic [numInts-1:0] pend_q, pend_d;
  logic [numInts-1:0] mask_q, mask_d;
  logic [numInts-1:0] in_service_q, in_service_d;
  logic               int_pending_q, int_pending_d;
  logic [idWidth-1:0] int_id_q, int_id_d;
  logic [pcWidth-1:0] int_addr_q, int_addr_d;

  logic [numInts-1:0] rise_s;
  logic [numInts-1:0] eligible_s;
  logic [numInts-1:0] ack_onehot_s;
  logic [numInts-1:0] eoi_onehot_s;
  logic [idWidth-1:0] win_s;
  logic [idWidth-1:0] top_s;
  logic               ack_accepted_s;
  logic               cand_s;

  // Index of the lowest set bit; the highest-priority channel wins the scan.
  function automatic logic [idWidth-1:0] lowest_index(input logic [numInts-1:0] v);
    logic [idWidth-1:0] idx;
    idx = {idWidth{1'b0}};
    for (int i = numInts - 1; i >= 0; i--) begin
      idx = v[i] ? idWidth'(i) : idx;
    end
    return idx;
  endfunction

  // Isolate the lowest set bit of a vector.
  function automatic logic [numInts-1:0] lowest_onehot(input logic [numInts-1:0] v);
    return v & (~v + numInts'(1));
  endfunction

  // Capture, arbitration and next-state computation for all registers.
  always_comb begin
    ints_d         = ints;
    rise_s         = ints & ~ints_q;
    ack_accepted_s = intAck & int_pending_q;

    if (ack_accepted_s) begin
      ack_onehot_s = numInts'(1) << int_id_q;
    end else begin
      ack_onehot_s = {numInts{1'b0}};
    end

    if (intEoi) begin
      eoi_onehot_s = lowest_onehot(in_service_q);
    end else begin
      eoi_onehot_s = {numInts{1'b0}};
    end

    // Edge channels latch until acked (a same-cycle edge re-arms them); level channels follow the line.
    pend_d = pend_q;
    for (int i = 0; i < numInts; i++) begin
      if (edgeTrig[i]) begin
        pend_d[i] = (pend_q[i] & ~ack_onehot_s[i]) | rise_s[i];
      end else begin
        pend_d[i] = ints[i];
      end
    end

    if (clrMask) begin
      mask_d = {numInts{1'b0}};
    end else if (ldMask) begin
      mask_d = maskIn;
    end else begin
      mask_d = mask_q;
    end

    eligible_s = pend_q & mask_q;
    win_s      = lowest_index(eligible_s);
    top_s      = lowest_index(in_service_q);
    cand_s     = (|eligible_s) &&
                 ((in_service_q == {numInts{1'b0}}) || (win_s < top_s));

    // EOI retires the pre-ack top entry; the acked channel is then added.
    in_service_d  = (in_service_q & ~eoi_onehot_s) | ack_onehot_s;
    int_pending_d = cand_s & ~intDisable & ~ack_accepted_s;

    if (cand_s) begin
      int_id_d   = win_s;
      int_addr_d = vecBase + (pcWidth'(win_s) << addrLen);
    end else begin
      int_id_d   = int_id_q;
      int_addr_d = int_addr_q;
    end
  end

  // State and output registers; async reset clears presentation without a clock.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ints_q        <= {numInts{1'b0}};
      pend_q        <= {numInts{1'b0}};
      mask_q        <= {numInts{1'b0}};
      in_service_q  <= {numInts{1'b0}};
      int_pending_q <= 1'b0;
      int_id_q      <= {idWidth{1'b0}};
      int_addr_q    <= {pcWidth{1'b0}};
    end else begin
      ints_q        <= ints_d;
      pend_q        <= pend_d;
      mask_q        <= mask_d;
      in_service_q  <= in_service_d;
      int_pending_q <= int_pending_d;
      int_id_q      <= int_id_d;
      int_addr_q    <= int_addr_d;
    end
  end

  assign intPending = int_pending_q;
  assign intId      = int_id_q;
  assign intAddr    = int_addr_q;
  assign inService  = in_service_q;

endmodule

// File: tb/tb_hpvi_ctrl.sv
// Directed bench for hpvi_ctrl: one all-edge instance driven from a vector table,
// plus a level-mode channel-0 instance exercised by hand-written sequences.
module tb_hpvi_ctrl;

  logic        clk;
  logic        rstN;
  logic [7:0]  ints, maskIn;
  logic        ldMask, clrMask, intDisable, intAck, intEoi;
  logic [15:0] vecBase;

  logic        pend_a, pend_b;
  logic [2:0]  id_a, id_b;
  logic [15:0] addr_a, addr_b;
  logic [7:0]  is_a, is_b;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  ints;
    logic        ld;
    logic [7:0]  msk;
    logic        clr;
    logic        dis;
    logic        ack;
    logic        eoi;
    logic        ep;
    logic [2:0]  eid;
    logic [15:0] ea;
    logic [7:0]  eis;
  } vec_t;

  vec_t tbl[58];

  hpvi_ctrl dut_edge (
    .clk(clk), .rstN(rstN), .ints(ints), .maskIn(maskIn), .ldMask(ldMask),
    .clrMask(clrMask), .intDisable(intDisable), .vecBase(vecBase),
    .intAck(intAck), .intEoi(intEoi), .intPending(pend_a), .intId(id_a),
    .intAddr(addr_a), .inService(is_a)
  );

  hpvi_ctrl #(.edgeTrig(8'hFE)) dut_lvl (
    .clk(clk), .rstN(rstN), .ints(ints), .maskIn(maskIn), .ldMask(ldMask),
    .clrMask(clrMask), .intDisable(intDisable), .vecBase(vecBase),
    .intAck(intAck), .intEoi(intEoi), .intPending(pend_b), .intId(id_b),
    .intAddr(addr_b), .inService(is_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [7:0] i_ints, input logic i_ld, input logic [7:0] i_msk,
                              input logic i_clr, input logic i_dis, input logic i_ack,
                              input logic i_eoi, input logic e_p, input logic [2:0] e_id,
                              input logic [15:0] e_a, input logic [7:0] e_is);
    vec_t v;
    v.ints = i_ints; v.ld = i_ld; v.msk = i_msk; v.clr = i_clr; v.dis = i_dis;
    v.ack = i_ack; v.eoi = i_eoi; v.ep = e_p; v.eid = e_id; v.ea = e_a; v.eis = e_is;
    return v;
  endfunction

  task automatic chk(input string nm, input bit sel, input logic ep, input logic [2:0] eid,
                     input logic [15:0] ea, input logic [7:0] eis);
    logic        ap;
    logic [2:0]  aid;
    logic [15:0] aa;
    logic [7:0]  ais;
    ap  = sel ? pend_b : pend_a;
    aid = sel ? id_b   : id_a;
    aa  = sel ? addr_b : addr_a;
    ais = sel ? is_b   : is_a;
    n_checks++;
    if (ap !== ep) begin
      n_fail++;
      $display("FAIL %s intPending got=%0b exp=%0b", nm, ap, ep);
    end
    n_checks++;
    if (aid !== eid) begin
      n_fail++;
      $display("FAIL %s intId got=%0d exp=%0d", nm, aid, eid);
    end
    n_checks++;
    if (aa !== ea) begin
      n_fail++;
      $display("FAIL %s intAddr got=%h exp=%h", nm, aa, ea);
    end
    n_checks++;
    if (ais !== eis) begin
      n_fail++;
      $display("FAIL %s inService got=%h exp=%h", nm, ais, eis);
    end
  endtask

  task automatic apply(input logic [7:0] i_ints, input logic i_ld, input logic i_ack,
                       input logic i_eoi);
    ints = i_ints; ldMask = i_ld; maskIn = 8'hFF; clrMask = 1'b0;
    intDisable = 1'b0; intAck = i_ack; intEoi = i_eoi;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           ints   ld    msk    clr   dis   ack   eoi   pend  id    addr      inService
    tbl[0]  = mk(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    tbl[1]  = mk(8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    tbl[2]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'h0114, 8'h00);
    tbl[3]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0114, 8'h20);
    tbl[4]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0114, 8'h20);
    tbl[5]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0114, 8'h00);
    tbl[6]  = mk(8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0114, 8'h00);
    tbl[7]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0108, 8'h00);
    tbl[8]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0108, 8'h04);
    tbl[9]  = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0108, 8'h04);
    tbl[10] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'h0108, 8'h00);
    tbl[11] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6, 16'h0118, 8'h00);
    tbl[12] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd6, 16'h0118, 8'h40);
    tbl[13] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 16'h0118, 8'h00);
    tbl[14] = mk(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 16'h0118, 8'h00);
    tbl[15] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0110, 8'h00);
    tbl[16] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 16'h0110, 8'h10);
    tbl[17] = mk(8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 16'h0110, 8'h10);
    tbl[18] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0104, 8'h10);
    tbl[19] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0104, 8'h12);
    tbl[20] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h0104, 8'h10);
    tbl[21] = mk(8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 16'h0104, 8'h10);
    tbl[22] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h010C, 8'h10);
    tbl[23] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd3, 16'h010C, 8'h08);
    tbl[24] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 16'h010C, 8'h00);
    tbl[25] = mk(8'h00, 1'b1, 8'hF7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h010C, 8'h00);
    tbl[26] = mk(8'h08, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h010C, 8'h00);
    tbl[27] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h010C, 8'h00);
    tbl[28] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h010C, 8'h00);
    tbl[29] = mk(8'h00, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h010C, 8'h00);
    tbl[30] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h010C, 8'h00);
    tbl[31] = mk(8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h010C, 8'h00);
    tbl[32] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h010C, 8'h00);
    tbl[33] = mk(8'h01, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 16'h010C, 8'h00);
    tbl[34] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0100, 8'h00);
    tbl[35] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0100, 8'h00);
    tbl[36] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0100, 8'h00);
    tbl[37] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0100, 8'h01);
    tbl[38] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0100, 8'h01);
    tbl[39] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0100, 8'h00);
    tbl[40] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 16'h010C, 8'h00);
    tbl[41] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 16'h010C, 8'h08);
    tbl[42] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 16'h010C, 8'h00);
    tbl[43] = mk(8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 16'h010C, 8'h00);
    tbl[44] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'h0114, 8'h00);
    tbl[45] = mk(8'h20, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0114, 8'h20);
    tbl[46] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0114, 8'h20);
    tbl[47] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0114, 8'h00);
    tbl[48] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 16'h0114, 8'h00);
    tbl[49] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd5, 16'h0114, 8'h20);
    tbl[50] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0114, 8'h00);
    tbl[51] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0114, 8'h00);
    tbl[52] = mk(8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0114, 8'h00);
    tbl[53] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0110, 8'h00);
    tbl[54] = mk(8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0110, 8'h00);
    tbl[55] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0110, 8'h00);
    tbl[56] = mk(8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0110, 8'h00);
    tbl[57] = mk(8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0100, 8'h00);

    rstN = 1'b0; ints = 8'h00; maskIn = 8'h00; ldMask = 1'b0; clrMask = 1'b0;
    intDisable = 1'b0; intAck = 1'b0; intEoi = 1'b0; vecBase = 16'h0100;
    #12;
    chk("reset_edge", 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    chk("reset_lvl", 1'b1, 1'b0, 3'd0, 16'h0000, 8'h00);
    @(negedge clk);
    rstN = 1'b1;

    for (int i = 0; i < 58; i++) begin
      ints = tbl[i].ints; ldMask = tbl[i].ld; maskIn = tbl[i].msk; clrMask = tbl[i].clr;
      intDisable = tbl[i].dis; intAck = tbl[i].ack; intEoi = tbl[i].eoi;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d", i), 1'b0, tbl[i].ep, tbl[i].eid, tbl[i].ea, tbl[i].eis);
    end

    // Reset while channel 0 is presented: outputs must clear before any clock edge.
    rstN = 1'b0;
    ints = 8'h00; ldMask = 1'b0; clrMask = 1'b0; intAck = 1'b0; intEoi = 1'b0;
    #1;
    chk("async_rst_edge", 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    @(negedge clk);
    rstN = 1'b1;

    // Level-mode channel 0 held high on dut_lvl; dut_edge sees the same lines.
    apply(8'h01, 1'b1, 1'b0, 1'b0);
    chk("t6a_lvl", 1'b1, 1'b0, 3'd0, 16'h0000, 8'h00);
    chk("t6a_edge", 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);
    apply(8'h01, 1'b0, 1'b0, 1'b0);
    chk("t6b_lvl", 1'b1, 1'b1, 3'd0, 16'h0100, 8'h00);
    chk("t6b_edge", 1'b0, 1'b1, 3'd0, 16'h0100, 8'h00);
    apply(8'h01, 1'b0, 1'b1, 1'b0);
    chk("t6c_lvl", 1'b1, 1'b0, 3'd0, 16'h0100, 8'h01);
    chk("t6c_edge", 1'b0, 1'b0, 3'd0, 16'h0100, 8'h01);
    apply(8'h01, 1'b0, 1'b0, 1'b0);
    chk("t6d_lvl", 1'b1, 1'b0, 3'd0, 16'h0100, 8'h01);
    apply(8'h01, 1'b0, 1'b0, 1'b1);
    chk("t6e_lvl", 1'b1, 1'b0, 3'd0, 16'h0100, 8'h00);
    chk("t6e_edge", 1'b0, 1'b0, 3'd0, 16'h0100, 8'h00);
    apply(8'h01, 1'b0, 1'b0, 1'b0);
    chk("t6f_lvl", 1'b1, 1'b1, 3'd0, 16'h0100, 8'h00);
    chk("t6f_edge", 1'b0, 1'b0, 3'd0, 16'h0100, 8'h00);
    apply(8'h00, 1'b0, 1'b0, 1'b0);
    chk("t6g_lvl", 1'b1, 1'b1, 3'd0, 16'h0100, 8'h00);
    apply(8'h00, 1'b0, 1'b0, 1'b0);
    chk("t6h_lvl", 1'b1, 1'b0, 3'd0, 16'h0100, 8'h00);
    apply(8'h01, 1'b0, 1'b0, 1'b0);
    chk("t6i_lvl", 1'b1, 1'b0, 3'd0, 16'h0100, 8'h00);
    apply(8'h01, 1'b0, 1'b0, 1'b0);
    chk("t6j_lvl", 1'b1, 1'b1, 3'd0, 16'h0100, 8'h00);
    chk("t6j_edge", 1'b0, 1'b1, 3'd0, 16'h0100, 8'h00);

    rstN = 1'b0;
    #1;
    chk("async_rst_lvl", 1'b1, 1'b0, 3'd0, 16'h0000, 8'h00);
    chk("async_rst_edge2", 1'b0, 1'b0, 3'd0, 16'h0000, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hpvi_ctrl.md
Name: hpvi_ctrl

Overview:
- Parametrised successor to the 4-channel hardware priority vectored interrupt system.
- Supports N channels, per-channel edge or level triggering, fixed priority (index 0 highest), and in-service tracking with nested preemption by higher priority only.
- Has an ack/EOI handshake with the CPU control unit.
- Produces the ISR address as a programmable vector base plus a scaled channel index.

Parameters:
- numInts, 8, number of interrupt channels (2..32).
- idWidth, 3, width of the channel index; must satisfy 2**idWidth >= numInts.
- pcWidth, 16, width of the PC and vector address.
- addrLen, 2, log2 of the vector table entry spacing in address units.
- edgeTrig, {numInts{1'b1}}, per-channel trigger mode: 1 = rising-edge, 0 = level-high.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  asynchronous active-low reset.
- ints  in  numInts  raw interrupt request lines, synchronous to clk.
- maskIn  in  numInts  mask load value; 1 = channel enabled.
- ldMask  in  1  load maskIn into the mask register.
- clrMask  in  1  clear the mask register, disabling all channels.
- intDisable  in  1  global disable of interrupt presentation.
- vecBase  in  pcWidth  vector table base address; static while intPending = 1.
- intAck  in  1  CPU accepts the presented interrupt.
- intEoi  in  1  CPU finished the current ISR.
- intPending  out  1  an interrupt is presented.
- intId  out  idWidth  index of the presented channel.
- intAddr  out  pcWidth  ISR address.
- inService  out  numInts  in-service register.

Behaviour:
- Reset (rstN low, asynchronous): clears intsQ, pend, mask, inService, intPending, intId and intAddr to 0.
- Reset asserted mid-operation drops intPending immediately, with no clock needed.
- Edge detect:
  - intsQ registers ints every cycle.
  - rise = ints & ~intsQ.
  - A line already high at the first clock after reset counts as a rising edge.
- Pending register, per channel i:
  - Edge mode: pend[i] <= (pend[i] & ~ackClr[i]) | rise[i]. If set and clear occur in the same cycle, set wins.
  - Level mode: pend[i] <= ints[i]. Ack does not clear it; the source must deassert.
  - ackClr is the one-hot of intId, qualified by an accepted ack.
- Mask register:
  - ldMask loads maskIn.
  - clrMask forces all bits to 0.
  - If both are asserted in the same cycle, clrMask wins.
  - Masking does not clear pend; a masked pending channel is presented once unmasked.
- Arbitration (combinational):
  - eligible = pend & mask.
  - win = lowest set index of eligible.
  - top = lowest set index of inService, or none.
  - cand = eligible nonzero AND (inService == 0 OR win < top).
- Registered outputs, every cycle:
  - intPending <= cand & ~intDisable & ~ackAccepted.
  - When cand: intId <= win and intAddr <= vecBase + (win << addrLen), truncated to pcWidth.
  - When not cand: intId and intAddr hold their previous values.
- Latency: a rising edge sampled at clock k sets pend at k; intPending, intId and intAddr are valid after clock k+1.
- Ack:
  - ackAccepted = intAck & intPending.
  - Sets inService[intId] and clears the edge-mode pend bit.
  - intPending is 0 the next cycle.
  - intAck while intPending = 0 is ignored.
- EOI:
  - Clears the lowest set bit of inService.
  - Ignored when inService = 0.
- Ack and EOI in the same cycle:
  - EOI applies to the pre-ack inService.
  - The ack bit is then set, so the newly acked channel stays in service.
- intDisable:
  - Holds intPending at 0 and blocks acks.
  - pend and inService continue to update.
- Presentation is never interrupted by a lower-priority arrival. A higher-priority arrival updates intId and intAddr while intPending stays 1.

Test Plan:
All cases use numInts=8, pcWidth=16, addrLen=2, vecBase=16'h0100 and mask loaded to 8'hFF unless stated.

1. Single-cycle pulse on ints[5] at clock k -> after clock k+1: intPending=1, intId=5, intAddr=16'h0114. Ack -> inService=8'h20 and intPending=0 the next cycle.
2. ints[6] and ints[2] rise together -> intId=2, intAddr=16'h0108. Ack -> intPending stays 0 because 6 > 2. EOI -> inService=0, then intId=6, intAddr=16'h0118.
3. Channel 4 in service, ints[1] rises:
   - Expect intPending=1, intId=1, and an ack gives inService=8'h12.
   - EOI -> inService=8'h10.
   - Ack+EOI issued together with channel 3 presented and inService=8'h10 -> inService=8'h08.
4. Mask 8'hF7, pulse ints[3] -> intPending stays 0. ldMask with 8'hFF -> intPending=1, intId=3, two cycles later. ldMask and clrMask asserted together -> mask=0 and intPending drops.
5. intDisable=1 with ints[0] pending -> intPending=0 and intAck is ignored (inService=0). Release intDisable -> intPending=1, intId=0, intAddr=16'h0100 on the next cycle.
6. edgeTrig=8'hFE, ints[0] held high:
   - Expect ack, then EOI, then channel 0 is re-presented.
   - Deassert ints[0] -> pend[0]=0 and intPending=0.
   - Drive rstN low mid-presentation -> all outputs 0 immediately, with no clock edge.
